// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    R_WB     = 4'd8,
    EXEC_I   = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    HALT     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Opcodes that zero-extend their immediate and use the logical ALU path.
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             branch_ne;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             ir_write;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src_a;
  logic             zero_ext;
  logic [1:0]       pc_source;
  logic [1:0]       alu_op;
  logic [1:0]       alu_src_b;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a, zero_ext,
           pc_source, alu_op, alu_src_b, halted, illegal, cycle_count, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a, zero_ext,
           pc_source, alu_op, alu_src_b, halted, illegal, cycle_count, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// over the shared datapath, with sticky halt status and bring-up counters.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int         CNT_W       = 32,
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic          clock,
  input  logic          reset_n,
  multicycle_ctrl_if.master bus
);

  state_t           state_q, state_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cycle_q, instr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:                  state_d = EXEC_R;
          OP_LW, OP_SW:              state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:            state_d = BRANCH;
          OP_J:                      state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = EXEC_I;
          default: begin
            state_d   = HALT;
            halted_d  = 1'b1;
            illegal_d = (bus.opcode != HALT_OPCODE);
          end
        endcase
      end
      MEM_ADDR: state_d = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (bus.mem_ready) state_d = MEM_WB;
      MEM_WR:   if (bus.mem_ready) state_d = FETCH;
      EXEC_R:   state_d = R_WB;
      EXEC_I:   state_d = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      if (state_q != IDLE && state_q != HALT) cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == FETCH && bus.mem_ready)  instr_q <= instr_q + CNT_W'(1);
    end
  end

  // Moore decode; only the FETCH IR/PC strobes look at mem_ready.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.zero_ext      = 1'b0;
    bus.pc_source     = PCSRC_ALU;
    bus.alu_op        = ALU_ADD;
    bus.alu_src_b     = SRCB_B;
    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE:   bus.alu_src_b = SRCB_IMM_SH2;
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.zero_ext  = is_logic_imm(bus.opcode);
        bus.alu_op    = is_logic_imm(bus.opcode) ? ALU_LOGIC : ALU_ADD;
      end
      I_WB:     bus.reg_write = 1'b1;
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        bus.branch_ne     = (bus.opcode == OP_BNE);
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors are
// queued when an instruction is issued and compared as the FSM steps.
module tb_multicycle_ctrl;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  multicycle_ctrl_if #(.CNT_W(32)) bus();

  multicycle_ctrl #(.CNT_W(32), .HALT_OPCODE(6'h3F)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Vector layout: {halted, illegal, pc_write, pc_write_cond, branch_ne, i_or_d,
  // mem_read, mem_write, mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a,
  // zero_ext, pc_source[1:0], alu_op[1:0], alu_src_b[1:0]}
  localparam logic [19:0] HLT  = 20'h1 << 19;
  localparam logic [19:0] ILL  = 20'h1 << 18;
  localparam logic [19:0] PCW  = 20'h1 << 17;
  localparam logic [19:0] PWC  = 20'h1 << 16;
  localparam logic [19:0] BNE  = 20'h1 << 15;
  localparam logic [19:0] IOD  = 20'h1 << 14;
  localparam logic [19:0] MR   = 20'h1 << 13;
  localparam logic [19:0] MW   = 20'h1 << 12;
  localparam logic [19:0] MTR  = 20'h1 << 11;
  localparam logic [19:0] IRW  = 20'h1 << 10;
  localparam logic [19:0] RW   = 20'h1 << 9;
  localparam logic [19:0] RD   = 20'h1 << 8;
  localparam logic [19:0] ASA  = 20'h1 << 7;
  localparam logic [19:0] ZE   = 20'h1 << 6;
  localparam logic [19:0] PCS_ALUOUT = 20'h10;
  localparam logic [19:0] PCS_JUMP   = 20'h20;
  localparam logic [19:0] AOP_SUB    = 20'h4;
  localparam logic [19:0] AOP_FUNCT  = 20'h8;
  localparam logic [19:0] AOP_LOGIC  = 20'hC;
  localparam logic [19:0] SB_FOUR    = 20'h1;
  localparam logic [19:0] SB_IMM     = 20'h2;
  localparam logic [19:0] SB_IMMSH   = 20'h3;

  typedef struct {
    logic [19:0] v;
    logic        rdy;
    bit          act;
    bit          fin;
    string       tag;
  } cyc_t;

  cyc_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc_m  = '0;
  logic [31:0] ins_m  = '0;

  function automatic logic [19:0] obs();
    return {bus.halted, bus.illegal, bus.pc_write, bus.pc_write_cond, bus.branch_ne,
            bus.i_or_d, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.ir_write,
            bus.reg_write, bus.reg_dst, bus.alu_src_a, bus.zero_ext,
            bus.pc_source, bus.alu_op, bus.alu_src_b};
  endfunction

  function automatic logic rnd();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [19:0] v, input logic rdy, input bit act,
                      input bit fin, input string tag);
    cyc_t c;
    c.v = v; c.rdy = rdy; c.act = act; c.fin = fin; c.tag = tag;
    sb.push_back(c);
  endtask

  task automatic issue(input logic [5:0] op, input int fw, input int mw);
    bus.opcode = op;
    for (int i = 0; i < fw; i++) push(MR | SB_FOUR, 1'b0, 1, 0, "fetch_wait");
    push(MR | SB_FOUR | IRW | PCW, 1'b1, 1, 1, "fetch");
    push(SB_IMMSH, rnd(), 1, 0, "decode");
    case (op)
      6'h00: begin
        push(ASA | AOP_FUNCT, rnd(), 1, 0, "exec_r");
        push(RW | RD, rnd(), 1, 0, "r_wb");
      end
      6'h23: begin
        push(ASA | SB_IMM, rnd(), 1, 0, "mem_addr");
        for (int i = 0; i < mw; i++) push(MR | IOD, 1'b0, 1, 0, "mem_rd_wait");
        push(MR | IOD, 1'b1, 1, 0, "mem_rd");
        push(RW | MTR, rnd(), 1, 0, "mem_wb");
      end
      6'h2B: begin
        push(ASA | SB_IMM, rnd(), 1, 0, "mem_addr");
        for (int i = 0; i < mw; i++) push(MW | IOD, 1'b0, 1, 0, "mem_wr_wait");
        push(MW | IOD, 1'b1, 1, 0, "mem_wr");
      end
      6'h04: push(ASA | AOP_SUB | PWC | PCS_ALUOUT, rnd(), 1, 0, "beq");
      6'h05: push(ASA | AOP_SUB | PWC | PCS_ALUOUT | BNE, rnd(), 1, 0, "bne");
      6'h02: push(PCW | PCS_JUMP, rnd(), 1, 0, "jump");
      6'h08: begin
        push(ASA | SB_IMM, rnd(), 1, 0, "exec_addi");
        push(RW, rnd(), 1, 0, "i_wb");
      end
      6'h0C, 6'h0D: begin
        push(ASA | SB_IMM | ZE | AOP_LOGIC, rnd(), 1, 0, "exec_logic");
        push(RW, rnd(), 1, 0, "i_wb");
      end
      default: begin
        for (int i = 0; i < 3; i++)
          push((op == 6'h3F) ? HLT : (HLT | ILL), rnd(), 0, 0, "halt");
      end
    endcase
  endtask

  task automatic drain_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && sb.size() > 0; i++) begin
      c = sb.pop_front();
      @(negedge clock);
      bus.mem_ready = c.rdy;
      #1;
      chk({12'h0, obs()}, {12'h0, c.v}, c.tag);
      chk(bus.cycle_count, cyc_m, {c.tag, "_cycle_count"});
      chk(bus.instr_count, ins_m, {c.tag, "_instr_count"});
      if (c.act) cyc_m++;
      if (c.fin) ins_m++;
    end
  endtask

  task automatic drain();
    drain_n(sb.size());
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    chk({12'h0, obs()}, 32'h0, "reset_controls");
    chk(bus.cycle_count, 32'h0, "reset_cycle_count");
    chk(bus.instr_count, 32'h0, "reset_instr_count");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk({12'h0, obs()}, 32'h0, "idle_controls");
    cyc_m = '0;
    ins_m = '0;
  endtask

  initial begin
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;
    apply_reset();

    issue(6'h00, 0, 0); drain();
    issue(6'h23, 0, 2); drain();
    issue(6'h2B, 1, 2); drain();
    issue(6'h05, 0, 0); drain();
    issue(6'h04, 2, 0); drain();
    issue(6'h02, 0, 0); drain();
    issue(6'h08, 0, 0); drain();
    issue(6'h0C, 1, 0); drain();
    issue(6'h0D, 0, 0); drain();
    issue(6'h23, 0, 0); drain();

    // Abort a store while MEM_WR is holding mem_write.
    issue(6'h2B, 0, 3);
    drain_n(4);
    sb.delete();
    #2;
    apply_reset();

    issue(6'h00, 0, 0); drain();
    issue(6'h3F, 0, 0); drain();

    apply_reset();
    issue(6'h11, 0, 0); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
